wash_cycle_ctrl: RTL

WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

---
 rtl/wash_cycle_ctrl_pkg.sv | 43 ++++
 rtl/wash_cycle_ctrl_bcd_down_counter.sv | 36 +++
 rtl/wash_cycle_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wash_cycle_ctrl_pkg.sv
// Shared definitions for the wash cycle controller: phase codes, default
// BCD phase durations and small helpers for BCD countdown and phase order.
package wash_cycle_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WASH  = 3'd1,
      RINSE = 3'd2,
      SPIN  = 3'd3,
      DONE  = 3'd4
   } phase_t;

   // Default durations, two BCD digits of seconds each.
   localparam logic [7:0] WASH_S_DEF  = 8'h30;
   localparam logic [7:0] RINSE_S_DEF = 8'h20;
   localparam logic [7:0] SPIN_S_DEF  = 8'h10;
   localparam logic [7:0] DONE_S_DEF  = 8'h03;

   // One-step BCD decrement; 00 saturates so the counter never wraps.
   function automatic logic [7:0] bcdDec(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h00)
         r = 8'h00;
      else if (v[3:0] == 4'h0)
         r = {v[7:4] - 4'h1, 4'h9};
      else
         r = {v[7:4], v[3:0] - 4'h1};
      return r;
   endfunction

   // Phase that follows p when its countdown expires.
   function automatic phase_t nextPhase(input phase_t p);
      phase_t n;
      case (p)
         WASH:    n = RINSE;
         RINSE:   n = SPIN;
         SPIN:    n = DONE;
         default: n = IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/wash_cycle_ctrl_bcd_down_counter.sv
// Two-digit BCD down counter holding the seconds remaining in a phase.
// Ports:
//   clk      - clock, rising edge
//   clr      - synchronous active-high clear to 00
//   load     - load loadVal (has priority over dec)
//   loadVal  - BCD value to load
//   dec      - decrement by one BCD step (saturates at 00)
//   count    - current BCD value
//   isZero   - count == 00
//   isOne    - count == 01
module bcd_down_counter
   import wash_cycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] loadVal,
   input  logic       dec,
   output logic [7:0] count,
   output logic       isZero,
   output logic       isOne
);

   always_ff @(posedge clk) begin
      if (clr)
         count <= 8'h00;
      else if (load)
         count <= loadVal;
      else if (dec)
         count <= bcdDec(count);
   end

   assign isZero = (count == 8'h00);
   assign isOne  = (count == 8'h01);

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing machine cycle sequencer: IDLE -> WASH -> RINSE -> SPIN -> DONE ->
// IDLE, each active phase lasting its BCD duration in 1 Hz ticks.
// Ports:
//   CLK_50M   - system clock, rising edge
//   CLR       - synchronous active-high reset
//   CLK_1Hz   - 1 Hz square wave synchronous to CLK_50M; rising edge = tick
//   Start     - one-cycle start request, honoured only in IDLE
//   Pause     - level; freezes the countdown and idles the actuators
//   Phase     - current phase code
//   Remaining - BCD seconds left in the current phase (00 only in IDLE)
//   Motor, WaterIn, Drain - actuator enables
//   Done      - cycle-complete indication
module wash_cycle_ctrl
   import wash_cycle_ctrl_pkg::*;
#(
   parameter logic [7:0] WASH_S  = WASH_S_DEF,
   parameter logic [7:0] RINSE_S = RINSE_S_DEF,
   parameter logic [7:0] SPIN_S  = SPIN_S_DEF,
   parameter logic [7:0] DONE_S  = DONE_S_DEF
)
(
   input  logic       CLK_50M,
   input  logic       CLR,
   input  logic       CLK_1Hz,
   input  logic       Start,
   input  logic       Pause,
   output logic [2:0] Phase,
   output logic [7:0] Remaining,
   output logic       Motor,
   output logic       WaterIn,
   output logic       Drain,
   output logic       Done
);

   phase_t     state;
   phase_t     nxtState;
   logic       clk1HzQ;
   logic       tick;
   logic       ldEn;
   logic [7:0] ldVal;
   logic       decEn;
   logic       cntZero;
   logic       cntOne;

   function automatic logic [7:0] durFor(input phase_t p);
      logic [7:0] d;
      case (p)
         WASH:    d = WASH_S;
         RINSE:   d = RINSE_S;
         SPIN:    d = SPIN_S;
         DONE:    d = DONE_S;
         default: d = 8'h00;
      endcase
      return d;
   endfunction

   // The delayed copy keeps sampling through CLR, so releasing reset while
   // CLK_1Hz is high does not look like a rising edge.
   always_ff @(posedge CLK_50M)
      clk1HzQ <= CLK_1Hz;

   assign tick = CLK_1Hz & ~clk1HzQ;

   always_comb begin
      nxtState = state;
      ldEn     = 1'b0;
      ldVal    = 8'h00;
      decEn    = 1'b0;
      case (state)
         IDLE: begin
            // A tick arriving with Start is swallowed: WASH begins full.
            if (Start) begin
               nxtState = WASH;
               ldEn     = 1'b1;
               ldVal    = WASH_S;
            end
         end
         WASH, RINSE, SPIN, DONE: begin
            if (tick && !Pause) begin
               if (cntOne) begin
                  nxtState = nextPhase(state);
                  ldEn     = 1'b1;
                  ldVal    = durFor(nextPhase(state));
               end else begin
                  decEn = !cntZero;
               end
            end
         end
         default: begin
            // Illegal codes fall back to a clean IDLE.
            nxtState = IDLE;
            ldEn     = 1'b1;
            ldVal    = 8'h00;
         end
      endcase
   end

   bcd_down_counter uCnt (
      .clk     (CLK_50M),
      .clr     (CLR),
      .load    (ldEn),
      .loadVal (ldVal),
      .dec     (decEn),
      .count   (Remaining),
      .isZero  (cntZero),
      .isOne   (cntOne)
   );

   // Actuators follow the next state; Pause gates them off one cycle later.
   always_ff @(posedge CLK_50M) begin
      if (CLR) begin
         state   <= IDLE;
         Motor   <= 1'b0;
         WaterIn <= 1'b0;
         Drain   <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state   <= nxtState;
         Motor   <= (nxtState == WASH || nxtState == RINSE || nxtState == SPIN) && !Pause;
         WaterIn <= (nxtState == RINSE) && !Pause;
         Drain   <= (nxtState == SPIN) && !Pause;
         Done    <= (nxtState == DONE);
      end
   end

   assign Phase = state;

endmodule
